// File: rtl/frame_sync.sv
// frame_sync: hunts for a header byte, collects a fixed-length frame into one
// half of a ping-pong buffer, validates its mod-256 checksum and replays good
// frames byte by byte from the other half toward the frame parser.
module frame_sync #(
    parameter logic [7:0] HDR       = 8'hA5,
    parameter int         FRAME_LEN = 76,
    parameter int         TIMEOUT   = 50000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  odata,
    output logic        odata_valid,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] err_cnt,
    output logic        locked
);
    localparam int                IDX_W    = $clog2(FRAME_LEN);
    localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT - 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [7:0]        sum_q, sum_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              bank_q, bank_d;
    logic              rep_bank_q, rep_bank_d;
    logic              vld_p0_q, vld_p0_d;     // replay read stage: address valid
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [7:0]        odata_q, odata_d;       // replay output stage
    logic              odata_valid_q, odata_valid_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              locked_q, locked_d;

    logic [7:0]        mem [2][FRAME_LEN];
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [7:0]        rd_byte;
    logic              err_evt;

    assign rd_byte = mem[rep_bank_q][rd_idx_q];

    // Next-state logic: collect FSM, checksum decision, timeout and replay sequencing
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        sum_d         = sum_q;
        idle_d        = idle_q;
        bank_d        = bank_q;
        rep_bank_d    = rep_bank_q;
        vld_p0_d      = vld_p0_q;
        rd_idx_d      = rd_idx_q;
        odata_d       = odata_q;
        odata_valid_d = vld_p0_q;
        frame_ok_d    = 1'b0;
        frame_err_d   = 1'b0;
        err_cnt_d     = err_cnt_q;
        locked_d      = locked_q;
        wr_en         = 1'b0;
        wr_idx        = count_q;
        err_evt       = 1'b0;

        // Replay: one bank read per cycle, the read byte lands in odata next edge
        if (vld_p0_q) begin
            odata_d = rd_byte;
            if (rd_idx_q == LAST_IDX) begin
                vld_p0_d = 1'b0;
                rd_idx_d = '0;
            end else begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
            end
        end

        if (state_q == HUNT) begin
            if (rx_valid && (rx_data == HDR)) begin
                wr_en   = 1'b1;
                wr_idx  = '0;
                state_d = COLLECT;
                count_d = IDX_W'(1);
                sum_d   = rx_data;
                idle_d  = '0;
            end
        end else begin
            if (rx_valid) begin
                wr_en  = 1'b1;
                idle_d = '0;
                if (count_q == LAST_IDX) begin
                    state_d = HUNT;
                    count_d = '0;
                    // A passing frame is only handed over when no replay is in flight
                    if ((rx_data == sum_q) && !(vld_p0_q || odata_valid_q)) begin
                        frame_ok_d = 1'b1;
                        locked_d   = 1'b1;
                        rep_bank_d = bank_q;
                        bank_d     = ~bank_q;
                        vld_p0_d   = 1'b1;
                        rd_idx_d   = '0;
                    end else begin
                        err_evt = 1'b1;
                    end
                end else begin
                    count_d = count_q + IDX_W'(1);
                    sum_d   = sum_q + rx_data;
                end
            end else if (idle_q == IDLE_LIM) begin
                state_d = HUNT;
                count_d = '0;
                idle_d  = '0;
                err_evt = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end

        if (err_evt) begin
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= HUNT;
            count_q       <= '0;
            sum_q         <= '0;
            idle_q        <= '0;
            bank_q        <= 1'b0;
            rep_bank_q    <= 1'b0;
            vld_p0_q      <= 1'b0;
            rd_idx_q      <= '0;
            odata_q       <= '0;
            odata_valid_q <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= '0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            sum_q         <= sum_d;
            idle_q        <= idle_d;
            bank_q        <= bank_d;
            rep_bank_q    <= rep_bank_d;
            vld_p0_q      <= vld_p0_d;
            rd_idx_q      <= rd_idx_d;
            odata_q       <= odata_d;
            odata_valid_q <= odata_valid_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            err_cnt_q     <= err_cnt_d;
            locked_q      <= locked_d;
        end
    end

    // Ping-pong frame storage; contents are left untouched by reset
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[bank_q][wr_idx] <= rx_data;
        end
    end

    assign odata       = odata_q;
    assign odata_valid = odata_valid_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign err_cnt     = err_cnt_q;
    assign locked      = locked_q;

endmodule
